wav_dfi_sideband_arb: RTL
=========================

// Module: wav_dfi_sideband_arb
// PURPOSE
//  MC-side controller for the DFI sideband interfaces: ctrlupd, phyupd, phymstr, lp_ctrl/lp_data.
//  Arbitrates MC update/low-power requests against PHY update/master requests; at most one handshake owns DFI.
//  Holds MC command path off while PHY owns DFI. Enforces tphyupd_resp, tlp_resp and ctrlupd min/max timing.
//  Sits between MC scheduler and DFI boundary.
// PARAMETERS
//  TPHYUPD_RESP  16  max cycles phyupd_req -> phyupd_ack
//  TLP_RESP       8  cycles lp req waits for both acks before withdrawing
//  TCTRLUPD_MIN   4  min cycles dfi_ctrlupd_req held high
//  TCTRLUPD_MAX  64  max cycles dfi_ctrlupd_req held high (forced drop)
// PORTS
//  clock               in   1  DFI clock
//  reset               in   1  async, active-low; all state/outputs cleared
//  init_start          in   1  training in progress; blocks/aborts all grants
//  mc_cmd_idle         in   1  MC command/rd/wr path idle (address 0, no en)
//  mc_ctrlupd_req      in   1  MC wants ctrl update (level)
//  mc_lp_req           in   1  MC wants low power (level)
//  mc_lp_wakeup        in   6  wakeup code for lp_ctrl/lp_data
//  mc_ctrlupd_gnt      out  1  ctrlupd acked by PHY
//  mc_lp_gnt           out  1  LP entered (both acks)
//  mc_lp_denied        out  1  1-cycle pulse: LP not acked within TLP_RESP
//  mc_phy_hold         out  1  MC must stop issuing commands
//  dfi_ctrlupd_req     out  1  /  dfi_ctrlupd_ack in 1
//  dfi_phyupd_req      in   1  /  dfi_phyupd_type in 2  /  dfi_phyupd_ack out 1
//  dfi_phymstr_req     in   1  /  dfi_phymstr_ack out 1
//  dfi_lp_ctrl_req     out  1  /  dfi_lp_ctrl_wakeup out 6  /  dfi_lp_ctrl_ack in 1
//  dfi_lp_data_req     out  1  /  dfi_lp_data_wakeup out 6  /  dfi_lp_data_ack in 1
//  arb_state           out  3  current FSM state (debug/coverage)
//  err_phyupd_late     out  1  pulse: phyupd_ack not given within TPHYUPD_RESP
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. All DFI outputs registered.
//  States: IDLE, PHYUPD, PHYMSTR, CTRLUPD, LP_REQ, LP_ACTIVE, LP_EXIT.
//  IDLE grant priority: phyupd > phymstr > ctrlupd > lp; needs !init_start & mc_cmd_idle
//   (ctrlupd/lp also need acks low). Min 1 cycle in IDLE between ownerships.
//  mc_phy_hold = phyupd_req|phymstr_req pending, or state PHYUPD/PHYMSTR.
//  PHYUPD: ack=1 next cycle after grant; stays while req=1; req seen 0 -> ack 0 next cycle, IDLE.
//   Resp counter starts at req rise; reaching TPHYUPD_RESP w/o ack -> err_phyupd_late pulse, still ack when idle.
//  PHYMSTR: identical handshake on phymstr_req/ack; no timeout.
//  CTRLUPD: dfi_ctrlupd_req=1; mc_ctrlupd_gnt=dfi_ctrlupd_ack (registered). Drop req when
//   (cnt>=TCTRLUPD_MIN & !mc_ctrlupd_req) or cnt==TCTRLUPD_MAX; then wait ack=0 -> IDLE.
//  LP_REQ: lp_ctrl_req=lp_data_req=1, wakeup=mc_lp_wakeup (sampled at entry, held).
//   Both acks -> LP_ACTIVE (mc_lp_gnt=1). TLP_RESP cycles w/o both acks -> reqs 0,
//   mc_lp_denied pulse, LP_EXIT. MC must drop mc_lp_req before retry (re-arm on its fall).
//  LP_ACTIVE: exit on !mc_lp_req or PHY req (phyupd/phymstr) -> reqs 0, LP_EXIT.
//  LP_EXIT: wait both acks 0 -> IDLE; pending PHY req then served.
//  Simultaneous PHY + MC requests in IDLE: PHY wins; MC request stays pending.
//  init_start=1 any state: all req/ack outputs 0 next cycle; LP states go LP_EXIT, others IDLE.
//  Counters saturate; width $clog2(max param)+1; no wrap.
//  Reset mid-handshake: outputs 0 immediately (async).
// STRUCTURE
//  wav_DFI_arb_pkg: arb_state_e enum (3b), priority encoding, default timing constants.
//  Sub-module wav_dfi_resp_timer: load/enable/saturating count/expire flag; one instance
//   per timed handshake (phyupd, ctrlupd, lp).
// TESTING
//  phyupd_req=1, mc_cmd_idle=1 -> phyupd_ack=1 in 2 cycles; req 0 -> ack 0 next cycle.
//  phyupd_req with mc_cmd_idle=0 for 20 cycles -> err_phyupd_late pulse at 16, ack after idle.
//  mc_lp_req=1, acks never rise -> lp reqs drop after 8 cycles, mc_lp_denied 1-cycle pulse.
//  LP_ACTIVE, phyupd_req rises -> lp reqs 0, acks 0, then phyupd_ack=1; mc_lp_gnt=0.
//  mc_ctrlupd_req held 100 cycles, ack=1 -> dfi_ctrlupd_req drops at cycle 64.
//  ctrlupd+phyupd same cycle in IDLE -> phyupd_ack first; init_start mid-CTRLUPD -> req 0 next cycle.

Source files
------------

// File: rtl/wav_dfi_sideband_arb_pkg.sv
// rtl/wav_dfi_sideband_arb_pkg.sv - shared types and timing defaults for the DFI sideband arbiter
// Contents: arbiter state encoding, IDLE grant priority encoder, default handshake timing.
package wav_dfi_sideband_arb_pkg;

    localparam int DEF_TPHYUPD_RESP = 16;
    localparam int DEF_TLP_RESP     = 8;
    localparam int DEF_TCTRLUPD_MIN = 4;
    localparam int DEF_TCTRLUPD_MAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PHYUPD    = 3'd1,
        ST_PHYMSTR   = 3'd2,
        ST_CTRLUPD   = 3'd3,
        ST_LP_REQ    = 3'd4,
        ST_LP_ACTIVE = 3'd5,
        ST_LP_EXIT   = 3'd6
    } arb_state_e;

    typedef enum logic [2:0] {
        GNT_NONE    = 3'd0,
        GNT_PHYUPD  = 3'd1,
        GNT_PHYMSTR = 3'd2,
        GNT_CTRLUPD = 3'd3,
        GNT_LP      = 3'd4
    } grant_e;

    // PHY-initiated handshakes always beat MC-initiated ones.
    function automatic grant_e pick_grant(input logic phyupd, input logic phymstr,
                                          input logic ctrlupd, input logic lp);
        if (phyupd)       return GNT_PHYUPD;
        else if (phymstr) return GNT_PHYMSTR;
        else if (ctrlupd) return GNT_CTRLUPD;
        else if (lp)      return GNT_LP;
        else              return GNT_NONE;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/wav_dfi_resp_timer.sv
// rtl/wav_dfi_resp_timer.sv - saturating handshake response timer
// Ports: clock, reset (async active-low), load (clear count to 0), enable (count up),
//        count (current value, saturates at LIMIT), expired (1-cycle pulse when LIMIT is reached).
module wav_dfi_resp_timer #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             expired
);

    localparam logic [WIDTH-1:0] LIM      = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] LIM_LAST = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                count <= '0;
            end else if (enable && (count != LIM)) begin
                count   <= count + ONE;
                expired <= (count == LIM_LAST);
            end
        end
    end

endmodule

// File: rtl/wav_dfi_sideband_arb.sv
// rtl/wav_dfi_sideband_arb.sv - MC-side arbiter for DFI ctrlupd/phyupd/phymstr/lp sideband handshakes
// Ports:
//   clock, reset (async active-low)
//   init_start, mc_cmd_idle, mc_ctrlupd_req, mc_lp_req, mc_lp_wakeup[5:0]  - MC scheduler side inputs
//   mc_ctrlupd_gnt, mc_lp_gnt, mc_lp_denied, mc_phy_hold                  - MC scheduler side outputs
//   dfi_ctrlupd_req/ack, dfi_phyupd_req/type/ack, dfi_phymstr_req/ack,
//   dfi_lp_ctrl_req/wakeup/ack, dfi_lp_data_req/wakeup/ack                 - DFI boundary
//   arb_state[2:0] (debug), err_phyupd_late (pulse on late phyupd ack)
module wav_dfi_sideband_arb
    import wav_dfi_sideband_arb_pkg::*;
#(
    parameter int TPHYUPD_RESP = DEF_TPHYUPD_RESP,
    parameter int TLP_RESP     = DEF_TLP_RESP,
    parameter int TCTRLUPD_MIN = DEF_TCTRLUPD_MIN,
    parameter int TCTRLUPD_MAX = DEF_TCTRLUPD_MAX
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init_start,
    input  logic       mc_cmd_idle,
    input  logic       mc_ctrlupd_req,
    input  logic       mc_lp_req,
    input  logic [5:0] mc_lp_wakeup,
    output logic       mc_ctrlupd_gnt,
    output logic       mc_lp_gnt,
    output logic       mc_lp_denied,
    output logic       mc_phy_hold,
    output logic       dfi_ctrlupd_req,
    input  logic       dfi_ctrlupd_ack,
    input  logic       dfi_phyupd_req,
    input  logic [1:0] dfi_phyupd_type,
    output logic       dfi_phyupd_ack,
    input  logic       dfi_phymstr_req,
    output logic       dfi_phymstr_ack,
    output logic       dfi_lp_ctrl_req,
    output logic [5:0] dfi_lp_ctrl_wakeup,
    input  logic       dfi_lp_ctrl_ack,
    output logic       dfi_lp_data_req,
    output logic [5:0] dfi_lp_data_wakeup,
    input  logic       dfi_lp_data_ack,
    output logic [2:0] arb_state,
    output logic       err_phyupd_late
);

    localparam int CNT_W = $clog2(max4(TPHYUPD_RESP, TLP_RESP, TCTRLUPD_MIN, TCTRLUPD_MAX)) + 1;

    // Timers start counting on the cycle after the request rises, so "held N cycles"
    // corresponds to a count of N-1 at the deciding edge.
    localparam logic [CNT_W-1:0] CU_MIN_LAST = CNT_W'(TCTRLUPD_MIN - 1);
    localparam logic [CNT_W-1:0] CU_MAX_LAST = CNT_W'(TCTRLUPD_MAX - 1);
    localparam logic [CNT_W-1:0] LP_LAST     = CNT_W'(TLP_RESP - 1);

    arb_state_e       state;
    logic             lp_blocked;
    logic [CNT_W-1:0] cu_cnt;
    logic [CNT_W-1:0] lp_cnt;
    logic [CNT_W-1:0] phy_cnt_unused;
    logic             cu_exp_unused;
    logic             lp_exp_unused;
    logic             unused_phyupd_type;
    logic             lp_acks_low;
    logic             cu_drop;
    grant_e           grant;

    assign unused_phyupd_type = ^dfi_phyupd_type;
    assign arb_state          = state;
    assign lp_acks_low        = !dfi_lp_ctrl_ack && !dfi_lp_data_ack;

    assign cu_drop = ((cu_cnt >= CU_MIN_LAST) && !mc_ctrlupd_req) || (cu_cnt >= CU_MAX_LAST);

    assign grant = pick_grant(dfi_phyupd_req,
                              dfi_phymstr_req,
                              mc_ctrlupd_req && !dfi_ctrlupd_ack,
                              mc_lp_req && !lp_blocked && lp_acks_low);

    // phyupd response window runs from req rise until ack, regardless of arbiter state.
    wav_dfi_resp_timer #(.WIDTH(CNT_W), .LIMIT(TPHYUPD_RESP)) u_phyupd_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (!dfi_phyupd_req || dfi_phyupd_ack),
        .enable  (1'b1),
        .count   (phy_cnt_unused),
        .expired (err_phyupd_late)
    );

    wav_dfi_resp_timer #(.WIDTH(CNT_W), .LIMIT(TCTRLUPD_MAX)) u_ctrlupd_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (!dfi_ctrlupd_req),
        .enable  (1'b1),
        .count   (cu_cnt),
        .expired (cu_exp_unused)
    );

    wav_dfi_resp_timer #(.WIDTH(CNT_W), .LIMIT(TLP_RESP)) u_lp_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (state != ST_LP_REQ),
        .enable  (1'b1),
        .count   (lp_cnt),
        .expired (lp_exp_unused)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= ST_IDLE;
            lp_blocked         <= 1'b0;
            mc_ctrlupd_gnt     <= 1'b0;
            mc_lp_gnt          <= 1'b0;
            mc_lp_denied       <= 1'b0;
            mc_phy_hold        <= 1'b0;
            dfi_ctrlupd_req    <= 1'b0;
            dfi_phyupd_ack     <= 1'b0;
            dfi_phymstr_ack    <= 1'b0;
            dfi_lp_ctrl_req    <= 1'b0;
            dfi_lp_data_req    <= 1'b0;
            dfi_lp_ctrl_wakeup <= 6'd0;
            dfi_lp_data_wakeup <= 6'd0;
        end else begin
            mc_lp_denied <= 1'b0;
            mc_phy_hold  <= dfi_phyupd_req || dfi_phymstr_req ||
                            (state == ST_PHYUPD) || (state == ST_PHYMSTR);
            // A denied LP request stays blocked until the MC drops mc_lp_req.
            if (!mc_lp_req) lp_blocked <= 1'b0;

            if (init_start) begin
                mc_ctrlupd_gnt  <= 1'b0;
                mc_lp_gnt       <= 1'b0;
                dfi_ctrlupd_req <= 1'b0;
                dfi_phyupd_ack  <= 1'b0;
                dfi_phymstr_ack <= 1'b0;
                dfi_lp_ctrl_req <= 1'b0;
                dfi_lp_data_req <= 1'b0;
                case (state)
                    ST_LP_REQ, ST_LP_ACTIVE: state <= ST_LP_EXIT;
                    ST_LP_EXIT:              state <= lp_acks_low ? ST_IDLE : ST_LP_EXIT;
                    default:                 state <= ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (mc_cmd_idle) begin
                            case (grant)
                                GNT_PHYUPD:  state <= ST_PHYUPD;
                                GNT_PHYMSTR: state <= ST_PHYMSTR;
                                GNT_CTRLUPD: begin
                                    state           <= ST_CTRLUPD;
                                    dfi_ctrlupd_req <= 1'b1;
                                end
                                GNT_LP: begin
                                    state              <= ST_LP_REQ;
                                    dfi_lp_ctrl_req    <= 1'b1;
                                    dfi_lp_data_req    <= 1'b1;
                                    dfi_lp_ctrl_wakeup <= mc_lp_wakeup;
                                    dfi_lp_data_wakeup <= mc_lp_wakeup;
                                end
                                default: state <= ST_IDLE;
                            endcase
                        end
                    end
                    ST_PHYUPD: begin
                        dfi_phyupd_ack <= dfi_phyupd_req;
                        if (!dfi_phyupd_req) state <= ST_IDLE;
                    end
                    ST_PHYMSTR: begin
                        dfi_phymstr_ack <= dfi_phymstr_req;
                        if (!dfi_phymstr_req) state <= ST_IDLE;
                    end
                    ST_CTRLUPD: begin
                        mc_ctrlupd_gnt <= dfi_ctrlupd_ack;
                        if (dfi_ctrlupd_req) begin
                            if (cu_drop) dfi_ctrlupd_req <= 1'b0;
                        end else if (!dfi_ctrlupd_ack) begin
                            state          <= ST_IDLE;
                            mc_ctrlupd_gnt <= 1'b0;
                        end
                    end
                    ST_LP_REQ: begin
                        if (dfi_lp_ctrl_ack && dfi_lp_data_ack) begin
                            state     <= ST_LP_ACTIVE;
                            mc_lp_gnt <= 1'b1;
                        end else if (lp_cnt >= LP_LAST) begin
                            state           <= ST_LP_EXIT;
                            dfi_lp_ctrl_req <= 1'b0;
                            dfi_lp_data_req <= 1'b0;
                            mc_lp_denied    <= 1'b1;
                            lp_blocked      <= 1'b1;
                        end
                    end
                    ST_LP_ACTIVE: begin
                        if (!mc_lp_req || dfi_phyupd_req || dfi_phymstr_req) begin
                            state           <= ST_LP_EXIT;
                            dfi_lp_ctrl_req <= 1'b0;
                            dfi_lp_data_req <= 1'b0;
                            mc_lp_gnt       <= 1'b0;
                        end
                    end
                    ST_LP_EXIT: begin
                        if (lp_acks_low) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
